dot_product_ctrl: RTL and testbench



---
 rtl/dot_pkg.sv | 28 ++
 rtl/dot_product_ctrl_if.sv | 24 ++
 rtl/dot_mac.sv | 35 +++
 rtl/dot_product_ctrl.sv | 156 +++++++++++++++
 tb/tb_dot_product_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dot_pkg.sv
// Shared types and constants for the APEX dot-product sequencer.
package dot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_A,
        WAIT_A,
        REQ_B,
        WAIT_B,
        MAC,
        WRITE,
        DONE
    } state_t;

    // Control word bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    // Status word bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_ABORTED = 3;

    // Byte distance between consecutive vector elements
    localparam int ELEM_BYTES = 4;

endpackage

// File: rtl/dot_product_ctrl_if.sv
// Memory-side handshake bundle: single-outstanding read port and a write port.
interface dot_product_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  o_rd_req;
    logic [DATA_WIDTH-1:0] o_rd_addr;
    logic                  i_rd_gnt;
    logic                  i_rd_valid;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic                  o_wr_req;
    logic [DATA_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] o_wr_data;
    logic                  i_wr_ack;

    modport master (
        output o_rd_req, o_rd_addr, o_wr_req, o_wr_addr, o_wr_data,
        input  i_rd_gnt, i_rd_valid, i_rd_data, i_wr_ack
    );

    modport slave (
        input  o_rd_req, o_rd_addr, o_wr_req, o_wr_addr, o_wr_data,
        output i_rd_gnt, i_rd_valid, i_rd_data, i_wr_ack
    );
endinterface

// File: rtl/dot_mac.sv
// Signed multiply-accumulate register with signed 32-bit range flag.
module dot_mac #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc,
    output logic                         ovf
);
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;

    assign prod     = a * b;
    assign prod_ext = ACC_WIDTH'(prod);

    // The result fits in DATA_WIDTH signed bits only when every bit from the
    // result sign bit upward is a copy of the sign.
    assign ovf = ~((&acc[ACC_WIDTH-1:DATA_WIDTH-1]) | ~(|acc[ACC_WIDTH-1:DATA_WIDTH-1]));

    // Accumulator: cleared at job start, one product added per MAC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end
endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: fetches A[i]/B[i], accumulates, writes the result.
module dot_product_ctrl
    import dot_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [31:0]           i_ctrl,
    input  logic [DATA_WIDTH-1:0] i_a_base,
    input  logic [DATA_WIDTH-1:0] i_b_base,
    input  logic [DATA_WIDTH-1:0] i_len,
    input  logic [DATA_WIDTH-1:0] i_out_addr,
    dot_product_ctrl_if.master    mem,
    output logic [31:0]           o_status
);
    state_t state, state_nx;

    logic                         start_q;
    logic                         start_edge;
    logic                         accept_start;
    logic                         busy_state;
    logic                         abort_req;
    logic [DATA_WIDTH-1:0]        a_ptr, b_ptr, out_addr, len_q, idx;
    logic signed [DATA_WIDTH-1:0] a_q, b_q;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic                         mac_ovf;
    logic                         st_busy, st_done, st_ovf, st_aborted;
    logic                         tie_unused;

    assign start_edge   = i_ctrl[CTRL_START] & ~start_q;
    assign accept_start = (state == IDLE) & start_edge;
    assign busy_state   = (state != IDLE) && (state != DONE);
    assign abort_req    = i_ctrl[CTRL_ABORT] & busy_state;
    assign tie_unused   = ^{i_ctrl[31:2], acc[ACC_WIDTH-1:DATA_WIDTH]};

    assign o_status = {28'd0, st_aborted, st_ovf, st_done, st_busy};

    dot_mac #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk(ACLK),
        .rst(ARESET),
        .clr(accept_start),
        .en (state == MAC),
        .a  (a_q),
        .b  (b_q),
        .acc(acc),
        .ovf(mac_ovf)
    );

    // State register.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort overrides any handshake seen in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_edge) state_nx = (i_len == '0) ? WRITE : REQ_A;
            REQ_A:   if (mem.i_rd_gnt) state_nx = WAIT_A;
            WAIT_A:  if (mem.i_rd_valid) state_nx = REQ_B;
            REQ_B:   if (mem.i_rd_gnt) state_nx = WAIT_B;
            WAIT_B:  if (mem.i_rd_valid) state_nx = MAC;
            MAC:     state_nx = (idx == len_q - DATA_WIDTH'(1)) ? WRITE : REQ_A;
            WRITE:   if (mem.i_wr_ack) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_req) begin
            state_nx = IDLE;
        end
    end

    // Job registers, operand capture, pointer stepping and sticky status bits.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            start_q    <= 1'b0;
            a_ptr      <= '0;
            b_ptr      <= '0;
            out_addr   <= '0;
            len_q      <= '0;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            st_busy    <= 1'b0;
            st_done    <= 1'b0;
            st_ovf     <= 1'b0;
            st_aborted <= 1'b0;
        end else begin
            start_q <= i_ctrl[CTRL_START];
            if (accept_start) begin
                a_ptr      <= i_a_base;
                b_ptr      <= i_b_base;
                out_addr   <= i_out_addr;
                len_q      <= i_len;
                idx        <= '0;
                st_busy    <= 1'b1;
                st_done    <= 1'b0;
                st_ovf     <= 1'b0;
                st_aborted <= 1'b0;
            end
            case (state)
                WAIT_A: if (mem.i_rd_valid) a_q <= mem.i_rd_data;
                WAIT_B: if (mem.i_rd_valid) b_q <= mem.i_rd_data;
                MAC: begin
                    a_ptr <= a_ptr + DATA_WIDTH'(ELEM_BYTES);
                    b_ptr <= b_ptr + DATA_WIDTH'(ELEM_BYTES);
                    idx   <= idx + DATA_WIDTH'(1);
                end
                DONE: begin
                    st_busy <= 1'b0;
                    st_done <= 1'b1;
                    st_ovf  <= mac_ovf;
                end
                default: ;
            endcase
            if (abort_req) begin
                st_busy    <= 1'b0;
                st_aborted <= 1'b1;
            end
        end
    end

    // Memory-port outputs decoded purely from registered state.
    always_comb begin
        mem.o_rd_req  = 1'b0;
        mem.o_rd_addr = '0;
        mem.o_wr_req  = 1'b0;
        mem.o_wr_addr = '0;
        mem.o_wr_data = '0;
        case (state)
            REQ_A: begin
                mem.o_rd_req  = 1'b1;
                mem.o_rd_addr = a_ptr;
            end
            REQ_B: begin
                mem.o_rd_req  = 1'b1;
                mem.o_rd_addr = b_ptr;
            end
            WRITE: begin
                mem.o_wr_req  = 1'b1;
                mem.o_wr_addr = out_addr;
                mem.o_wr_data = acc[DATA_WIDTH-1:0];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl with a scoreboarded memory model.
module tb_dot_product_ctrl;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] i_ctrl, i_a_base, i_b_base, i_len, i_out_addr, o_status;

    dot_product_ctrl_if #(.DATA_WIDTH(32)) bus ();

    dot_product_ctrl #(.DATA_WIDTH(32), .ACC_WIDTH(64)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .i_ctrl    (i_ctrl),
        .i_a_base  (i_a_base),
        .i_b_base  (i_b_base),
        .i_len     (i_len),
        .i_out_addr(i_out_addr),
        .mem       (bus),
        .o_status  (o_status)
    );

    int errors = 0;
    int checks = 0;
    int gnt_dly = 0;
    int val_dly = 1;
    int grant_cnt = 0;
    logic [31:0] exp_rd_q[$];
    logic [63:0] exp_wr_q[$];
    logic [31:0] mem_data[logic [31:0]];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mem_read(input logic [31:0] addr);
        if (mem_data.exists(addr)) return mem_data[addr];
        return 32'hDEADBEEF;
    endfunction

    // Read side of the memory: grants after gnt_dly cycles, returns data val_dly cycles later.
    initial begin : rd_responder
        int gcnt;
        int vcnt;
        logic [31:0] held;
        logic [31:0] pend;
        logic [31:0] exp_addr;
        gcnt = 0; vcnt = 0; held = 0; pend = 0;
        bus.i_rd_gnt = 1'b0; bus.i_rd_valid = 1'b0; bus.i_rd_data = '0;
        forever begin
            @(negedge ACLK);
            bus.i_rd_gnt   = 1'b0;
            bus.i_rd_valid = 1'b0;
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) begin
                    bus.i_rd_valid = 1'b1;
                    bus.i_rd_data  = mem_read(pend);
                end
            end else if (bus.o_rd_req) begin
                if (gcnt == 0) begin
                    held = bus.o_rd_addr;
                end else begin
                    checks++;
                    if (bus.o_rd_addr !== held) begin
                        errors++;
                        $display("[TB] FAIL rd_addr_stable: got %h required %h", bus.o_rd_addr, held);
                    end
                end
                if (gcnt >= gnt_dly) begin
                    bus.i_rd_gnt = 1'b1;
                    pend = bus.o_rd_addr;
                    vcnt = val_dly;
                    gcnt = 0;
                    grant_cnt++;
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL rd_unexpected: got read of %h required no read", bus.o_rd_addr);
                    end else begin
                        exp_addr = exp_rd_q.pop_front();
                        if (bus.o_rd_addr !== exp_addr) begin
                            errors++;
                            $display("[TB] FAIL rd_addr: got %h required %h", bus.o_rd_addr, exp_addr);
                        end
                    end
                end else begin
                    gcnt++;
                end
            end else begin
                gcnt = 0;
            end
        end
    end

    // Write side of the memory: acknowledges at once and scores address and data.
    initial begin : wr_responder
        logic [63:0] exp_wr;
        bus.i_wr_ack = 1'b0;
        forever begin
            @(negedge ACLK);
            bus.i_wr_ack = 1'b0;
            if (bus.o_wr_req) begin
                bus.i_wr_ack = 1'b1;
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wr_unexpected: got write %h to %h required no write", bus.o_wr_data, bus.o_wr_addr);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    if ({bus.o_wr_addr, bus.o_wr_data} !== exp_wr) begin
                        errors++;
                        $display("[TB] FAIL wr_addr_data: got %h/%h required %h/%h",
                                 bus.o_wr_addr, bus.o_wr_data, exp_wr[63:32], exp_wr[31:0]);
                    end
                end
            end
        end
    end

    // Loads memory, computes the expected result and queues the expected traffic, then pulses START.
    task automatic launch(input logic [31:0] a_base, input logic [31:0] b_base,
                          input logic [31:0] out_addr, input logic [31:0] av[$],
                          input logic [31:0] bv[$], input bit push_write,
                          output logic [31:0] exp_status);
        longint acc;
        longint lim_hi;
        longint lim_lo;
        logic [31:0] ad;
        logic [31:0] bd;
        acc = 0;
        lim_hi = 64'sd2147483647;
        lim_lo = -64'sd2147483648;
        for (int i = 0; i < av.size(); i++) begin
            ad = a_base + 32'(4 * i);
            bd = b_base + 32'(4 * i);
            mem_data[ad] = av[i];
            mem_data[bd] = bv[i];
            exp_rd_q.push_back(ad);
            exp_rd_q.push_back(bd);
            acc += longint'($signed(av[i])) * longint'($signed(bv[i]));
        end
        if (push_write) exp_wr_q.push_back({out_addr, acc[31:0]});
        exp_status = ((acc > lim_hi) || (acc < lim_lo)) ? 32'h6 : 32'h2;
        @(negedge ACLK);
        i_ctrl     = 32'h0;
        i_a_base   = a_base;
        i_b_base   = b_base;
        i_len      = 32'(av.size());
        i_out_addr = out_addr;
        @(negedge ACLK);
        i_ctrl = 32'h1;
    endtask

    // Runs one job to completion, counting cycles from the START-sampling edge to DONE in status.
    task automatic run_op(input logic [31:0] a_base, input logic [31:0] b_base,
                          input logic [31:0] out_addr, input logic [31:0] av[$],
                          input logic [31:0] bv[$], input bit retrig,
                          output int cyc, output logic [31:0] exp_status);
        bit done;
        launch(a_base, b_base, out_addr, av, bv, 1'b1, exp_status);
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 3000) begin
            @(posedge ACLK);
            #1;
            cyc++;
            if (retrig && cyc == 4) i_ctrl = 32'h0;
            if (retrig && cyc == 6) i_ctrl = 32'h1;
            if (o_status[1]) done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("[TB] FAIL done_timeout: got status %h required DONE within 3000 cycles", o_status);
        end
        repeat (3) @(negedge ACLK);
        i_ctrl = 32'h0;
        repeat (3) @(negedge ACLK);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if (o_status !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h required 0", o_status); end
        checks++;
        if ({bus.o_rd_req, bus.o_wr_req} !== 2'b00) begin errors++; $display("[TB] FAIL reset_req: got %b required 00", {bus.o_rd_req, bus.o_wr_req}); end
        checks++;
        if (bus.o_rd_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_addr: got %h required 0", bus.o_rd_addr); end
        checks++;
        if ({bus.o_wr_addr, bus.o_wr_data} !== 64'h0) begin errors++; $display("[TB] FAIL reset_wr_bus: got %h/%h required 0/0", bus.o_wr_addr, bus.o_wr_data); end
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        checks++;
        if ({o_status, bus.o_rd_req, bus.o_wr_req} !== 34'h0) begin errors++; $display("[TB] FAIL idle_after_reset: got status %h req %b%b required all 0", o_status, bus.o_rd_req, bus.o_wr_req); end
    endtask

    task automatic test_basic();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int cyc;
        gnt_dly = 0; val_dly = 1;
        av = {32'd1, 32'd2, 32'd3, 32'd4};
        bv = {32'd5, 32'd6, 32'd7, 32'd8};
        run_op(32'h1000, 32'h2000, 32'h3000, av, bv, 1'b0, cyc, es);
        checks++;
        if (cyc !== 3 + 5 * 4) begin errors++; $display("[TB] FAIL basic_cycles: got %0d required %0d", cyc, 3 + 5 * 4); end
        checks++;
        if (o_status !== es) begin errors++; $display("[TB] FAIL basic_status: got %h required %h", o_status, es); end
        checks++;
        if (exp_rd_q.size() + exp_wr_q.size() !== 0) begin errors++; $display("[TB] FAIL basic_traffic: got %0d outstanding required 0", exp_rd_q.size() + exp_wr_q.size()); end
    endtask

    task automatic test_negative();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int cyc;
        av = {32'hFFFFFFFD};
        bv = {32'd7};
        run_op(32'h4000, 32'h5000, 32'h6000, av, bv, 1'b0, cyc, es);
        checks++;
        if (o_status !== es) begin errors++; $display("[TB] FAIL negative_status: got %h required %h", o_status, es); end
        checks++;
        if (exp_wr_q.size() !== 0) begin errors++; $display("[TB] FAIL negative_write: got %0d pending required 0", exp_wr_q.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int cyc;
        av = {32'h7FFFFFFF, 32'h7FFFFFFF};
        bv = {32'd2, 32'd2};
        run_op(32'h7000, 32'h8000, 32'h9000, av, bv, 1'b0, cyc, es);
        checks++;
        if (o_status !== es) begin errors++; $display("[TB] FAIL overflow_status: got %h required %h", o_status, es); end
        checks++;
        if (cyc !== 3 + 5 * 2) begin errors++; $display("[TB] FAIL overflow_cycles: got %0d required %0d", cyc, 3 + 5 * 2); end
    endtask

    task automatic test_zero_len();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int cyc;
        int g0;
        g0 = grant_cnt;
        run_op(32'hA000, 32'hB000, 32'hC000, av, bv, 1'b0, cyc, es);
        checks++;
        if (cyc !== 3) begin errors++; $display("[TB] FAIL zero_cycles: got %0d required 3", cyc); end
        checks++;
        if (grant_cnt !== g0) begin errors++; $display("[TB] FAIL zero_reads: got %0d reads required 0", grant_cnt - g0); end
        checks++;
        if (o_status !== es) begin errors++; $display("[TB] FAIL zero_status: got %h required %h", o_status, es); end
        checks++;
        if (exp_wr_q.size() !== 0) begin errors++; $display("[TB] FAIL zero_write: got %0d pending required 0", exp_wr_q.size()); end
    endtask

    task automatic test_delayed();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int cyc;
        int g0;
        gnt_dly = 3; val_dly = 3;
        av = {32'd10, 32'hFFFFFFEC, 32'd30};
        bv = {32'hFFFFFFFC, 32'd5, 32'd6};
        run_op(32'hFFFFFFF8, 32'h0000D000, 32'h0000E000, av, bv, 1'b1, cyc, es);
        g0 = grant_cnt;
        repeat (20) @(negedge ACLK);
        checks++;
        if (grant_cnt !== g0) begin errors++; $display("[TB] FAIL delayed_retrigger: got %0d extra reads required 0", grant_cnt - g0); end
        checks++;
        if (o_status !== es) begin errors++; $display("[TB] FAIL delayed_status: got %h required %h", o_status, es); end
        checks++;
        if (exp_rd_q.size() + exp_wr_q.size() !== 0) begin errors++; $display("[TB] FAIL delayed_traffic: got %0d outstanding required 0", exp_rd_q.size() + exp_wr_q.size()); end
        gnt_dly = 0; val_dly = 1;
    endtask

    task automatic test_abort();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int g0;
        int n;
        val_dly = 3;
        av = {32'd1, 32'd2, 32'd3};
        bv = {32'd4, 32'd5, 32'd6};
        g0 = grant_cnt;
        launch(32'h1100, 32'h2200, 32'h3300, av, bv, 1'b0, es);
        n = 0;
        while ((grant_cnt - g0) < 4 && n < 200) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        checks++;
        if (grant_cnt - g0 !== 4) begin errors++; $display("[TB] FAIL abort_reach_wait_b: got %0d reads required 4", grant_cnt - g0); end
        i_ctrl = 32'h2;
        @(posedge ACLK);
        #1;
        checks++;
        if ({bus.o_rd_req, bus.o_wr_req} !== 2'b00) begin errors++; $display("[TB] FAIL abort_req: got %b required 00", {bus.o_rd_req, bus.o_wr_req}); end
        exp_rd_q.delete();
        @(posedge ACLK);
        #1;
        checks++;
        if (o_status !== 32'h8) begin errors++; $display("[TB] FAIL abort_status: got %h required 8", o_status); end
        @(negedge ACLK);
        i_ctrl = 32'h0;
        repeat (10) @(negedge ACLK);
        checks++;
        if (o_status !== 32'h8) begin errors++; $display("[TB] FAIL abort_sticky: got %h required 8", o_status); end
        val_dly = 1;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        av = {32'd9, 32'd8, 32'd7};
        bv = {32'd1, 32'd1, 32'd1};
        launch(32'h1400, 32'h2400, 32'h3400, av, bv, 1'b1, es);
        repeat (8) @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        #1;
        checks++;
        if (o_status !== 32'h0) begin errors++; $display("[TB] FAIL midreset_status: got %h required 0", o_status); end
        checks++;
        if ({bus.o_rd_req, bus.o_wr_req, bus.o_rd_addr} !== 34'h0) begin errors++; $display("[TB] FAIL midreset_rd: got req %b%b addr %h required 0", bus.o_rd_req, bus.o_wr_req, bus.o_rd_addr); end
        checks++;
        if ({bus.o_wr_addr, bus.o_wr_data} !== 64'h0) begin errors++; $display("[TB] FAIL midreset_wr: got %h/%h required 0/0", bus.o_wr_addr, bus.o_wr_data); end
        exp_rd_q.delete();
        exp_wr_q.delete();
        i_ctrl = 32'h0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        repeat (3) @(negedge ACLK);
    endtask

    task automatic test_after_reset();
        logic [31:0] av[$];
        logic [31:0] bv[$];
        logic [31:0] es;
        int cyc;
        av = {32'd100, 32'hFFFFFFFF};
        bv = {32'd3, 32'h80000000};
        run_op(32'h1800, 32'h2800, 32'h3800, av, bv, 1'b0, cyc, es);
        checks++;
        if (cyc !== 3 + 5 * 2) begin errors++; $display("[TB] FAIL after_reset_cycles: got %0d required %0d", cyc, 3 + 5 * 2); end
        checks++;
        if (o_status !== es) begin errors++; $display("[TB] FAIL after_reset_status: got %h required %h", o_status, es); end
        checks++;
        if (exp_rd_q.size() + exp_wr_q.size() !== 0) begin errors++; $display("[TB] FAIL after_reset_traffic: got %0d outstanding required 0", exp_rd_q.size() + exp_wr_q.size()); end
    endtask

    initial begin
        ARESET     = 1'b1;
        i_ctrl     = 32'h0;
        i_a_base   = 32'h0;
        i_b_base   = 32'h0;
        i_len      = 32'h0;
        i_out_addr = 32'h0;
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_zero_len();
        test_delayed();
        test_abort();
        test_reset_mid_run();
        test_after_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
